// File: rtl/if_id_queue.sv
// Purpose     : elastic IF/ID buffer; holds fetched {pc, instr} pairs and presents the oldest to ID.
// Latency     : 1 cycle from accepted push to head visibility; no same-cycle bypass.
// Backpressure: in_ready = (count < DEPTH), state-only; a pop never frees a slot in the same cycle.
//
// Ports:
//   clk, rst                 - core clock; asynchronous active-low reset
//   in_valid/in_ready        - fetch handshake; ~in_ready freezes IF
//   pc_in, instr_in          - fetched pc and instruction word
//   flush                    - taken branch; drops every entry at the next edge
//   out_valid/out_ready      - decode handshake; out_ready low = ID hazard stall
//   pc_out, instr_out        - head entry, zeroed when empty so ID sees a bubble
//   count                    - occupancy 0..DEPTH
module if_id_queue #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic [DATA_W-1:0]        instr_in,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        pc_out,
    output logic [DATA_W-1:0]        instr_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    entry_t             head;

    // Both flags come from registered occupancy only, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Wrong-path entries die together; any same-cycle push/pop is dropped.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= '{pc: pc_in, instr: instr_in};
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign pc_out    = out_valid ? head.pc    : '0;
    assign instr_out = out_valid ? head.instr : '0;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] pc_in = '0;
    logic [DATA_W-1:0] instr_in = '0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] instr_out;
    logic [CW-1:0]     count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: an ordered list of stored {pc, instr} pairs.
    logic [2*DATA_W-1:0] mq[$];

    if_id_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc_in),
        .instr_in(instr_in), .in_ready(in_ready), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
        .instr_out(instr_out), .count(count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [DATA_W-1:0] pc,
                         input logic [DATA_W-1:0] ins, input logic ordy, input logic fl);
        in_valid  = v;
        pc_in     = pc;
        instr_in  = ins;
        out_ready = ordy;
        flush     = fl;
    endtask

    // One rising edge; the model applies the queue rules to the inputs that
    // were stable across that edge, then returns 1 time unit later.
    task automatic cycle();
        bit do_push;
        bit do_pop;
        @(posedge clk);
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = out_ready && (mq.size() != 0);
        if (flush) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({pc_in, instr_in});
        end
        #1;
    endtask

    function automatic logic [CW+2*DATA_W+1:0] model_outs();
        int  n = mq.size();
        logic v = (n != 0);
        return {v, (n < DEPTH), CW'(n), (v ? mq[0] : {2*DATA_W{1'b0}})};
    endfunction

    function automatic logic [CW+2*DATA_W+1:0] dut_outs();
        return {out_valid, in_ready, count, pc_out, instr_out};
    endfunction

    task automatic test_reset();
        #1;
        vectors++;
        if ({out_valid, in_ready, count, pc_out, instr_out} !== {1'b0, 1'b1, CW'(0), 64'h0}) begin
            miscompares++;
            $display("FAIL reset_initial got=%h want=%h", dut_outs(),
                     {1'b0, 1'b1, CW'(0), 64'h0});
        end
        #2 rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, DATA_W'(i), 32'hA000_0000 + DATA_W'(i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++;
        if (count !== CW'(2)) begin
            miscompares++;
            $display("FAIL reset_prefill count got=%0d want=2", count);
        end
        // Drop reset between edges; outputs must clear with no clock.
        #2 rst = 1'b0;
        mq.delete();
        #1;
        vectors++;
        if ({out_valid, in_ready, count, pc_out, instr_out} !== {1'b0, 1'b1, CW'(0), 64'h0}) begin
            miscompares++;
            $display("FAIL reset_async got=%h want=%h", dut_outs(),
                     {1'b0, 1'b1, CW'(0), 64'h0});
        end
        #1 rst = 1'b1;
        drive(1'b1, 32'h100, 32'h1234_5678, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++;
        if ({out_valid, count, pc_out, instr_out} !== {1'b1, CW'(1), 32'h100, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL reset_first_push got pc=%h cnt=%0d want pc=100 cnt=1", pc_out, count);
        end
        cycle();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_fill_full();
        drive(1'b1, 32'd1, 32'hE3A0_0001, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'd2, 32'hE3A0_1002, 1'b0, 1'b0);
        cycle();
        vectors++;
        if ({count, in_ready, pc_out, instr_out} !== {CW'(2), 1'b0, 32'd1, 32'hE3A0_0001}) begin
            miscompares++;
            $display("FAIL fill_full got cnt=%0d rdy=%b pc=%h ins=%h want cnt=2 rdy=0 pc=1 ins=e3a00001",
                     count, in_ready, pc_out, instr_out);
        end
        drive(1'b1, 32'd3, 32'hE3A0_2003, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++;
        if ({count, pc_out} !== {CW'(2), 32'd1}) begin
            miscompares++;
            $display("FAIL full_ignore got cnt=%0d pc=%h want cnt=2 pc=1", count, pc_out);
        end
    endtask

    task automatic test_drain();
        logic [DATA_W-1:0] exp_pc[3]  = '{32'd2, 32'd0, 32'd0};
        logic [CW-1:0]     exp_cnt[3] = '{CW'(1), CW'(0), CW'(0)};
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if ({pc_out, count, out_valid} !== {exp_pc[i], exp_cnt[i], (exp_cnt[i] != 0)}) begin
                miscompares++;
                $display("FAIL drain[%0d] got pc=%h cnt=%0d vld=%b want pc=%h cnt=%0d",
                         i, pc_out, count, out_valid, exp_pc[i], exp_cnt[i]);
            end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'd5, 32'h55, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'd6, 32'h66, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++;
        if ({count, pc_out, instr_out} !== {CW'(1), 32'd6, 32'h66}) begin
            miscompares++;
            $display("FAIL push_pop got cnt=%0d pc=%h want cnt=1 pc=6", count, pc_out);
        end
        drive(1'b1, 32'd7, 32'h77, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        // Queue holds pc 6,7 (full); in_valid with pc=7 and a pop request are both discarded.
        drive(1'b1, 32'd7, 32'h77, 1'b1, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++;
        if ({count, out_valid, pc_out} !== {CW'(0), 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL flush_full got cnt=%0d vld=%b pc=%h want 0/0/0", count, out_valid, pc_out);
        end
        drive(1'b1, 32'd20, 32'h2020, 1'b0, 1'b0);
        cycle();
        vectors++;
        if ({count, pc_out} !== {CW'(1), 32'd20}) begin
            miscompares++;
            $display("FAIL flush_refill got cnt=%0d pc=%h want cnt=1 pc=14", count, pc_out);
        end
        // Not full: IF must not be frozen during the flush, yet its fetch is dropped.
        drive(1'b1, 32'd30, 32'h3030, 1'b0, 1'b1);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_in_ready got=%b want=1", in_ready);
        end
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++;
        if ({count, out_valid, pc_out} !== {CW'(0), 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL flush_drop_push got cnt=%0d vld=%b pc=%h want 0/0/0", count, out_valid, pc_out);
        end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] got[$];
        int next_pc = 1;
        int cyc = 0;
        bit over = 0;
        while ((got.size() < 9) && (cyc < 100)) begin
            drive(next_pc <= 9, DATA_W'(next_pc), DATA_W'(next_pc) ^ 32'hFFFF, (cyc % 2) == 0, 1'b0);
            #1;
            if (out_valid && out_ready) got.push_back(pc_out);
            if (in_valid && in_ready) next_pc++;
            cycle();
            if (count > CW'(2)) over = 1;
            vectors++;
            if (dut_outs() !== model_outs()) begin
                miscompares++;
                $display("FAIL wrap_cycle[%0d] got=%h want=%h", cyc, dut_outs(), model_outs());
            end
            cyc++;
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++;
        if (got.size() != 9 || over) begin
            miscompares++;
            $display("FAIL wrap_total got=%0d outputs overfull=%0d want=9 outputs overfull=0", got.size(), over);
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== DATA_W'(i + 1)) begin
                miscompares++;
                $display("FAIL wrap_order[%0d] got=%0d want=%0d", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            #1;
            vectors++;
            if (dut_outs() !== model_outs()) begin
                miscompares++;
                $display("FAIL rand_pre[%0d] got=%h want=%h", i, dut_outs(), model_outs());
            end
            cycle();
            vectors++;
            if (dut_outs() !== model_outs()) begin
                miscompares++;
                $display("FAIL rand_post[%0d] got=%h want=%h", i, dut_outs(), model_outs());
            end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_drain();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Elastic IF/ID boundary buffer. Sits directly downstream of the fetch stage and feeds the decode stage.
- Captures each fetched {pc, instruction} pair into a small FIFO and presents the oldest entry to ID.
- Converts ID backpressure into a fetch freeze.
- Discards all wrong-path entries in one cycle on a taken branch.

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- DATA_W, 32, width of the pc and instruction fields.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  IF presents a valid fetch this cycle.
- pc_in  input  DATA_W  pc value from IF.
- instr_in  input  DATA_W  instruction word from IF.
- in_ready  output  1  queue can accept; IF freeze = ~in_ready.
- flush  input  1  branch taken; discard all entries.
- out_valid  output  1  head entry valid for ID.
- out_ready  input  1  ID consumes head this cycle; low = hazard stall.
- pc_out  output  DATA_W  head pc.
- instr_out  output  DATA_W  head instruction.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - count=0, read/write pointers=0, out_valid=0, pc_out=0, instr_out=0, in_ready=1.
  - Storage contents need not be cleared.
  - Assertion mid-operation drops all entries immediately.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count < DEPTH).
  - Depends only on state, never on out_ready; there is no combinational in->out path.
- out_valid = (count != 0).
- pc_out and instr_out show the head entry when out_valid=1 and are forced to 0 when out_valid=0, so ID decodes an all-zero bubble.
- Latency: an entry pushed at edge N appears at the outputs after edge N (1 cycle). There is no same-cycle bypass.
- Per edge, with flush=0:
  - push only: write at wr_ptr, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - push and pop: both pointers advance, count unchanged.
  - neither: hold.
- Flush (synchronous):
  - When flush=1 at an edge: count=0, rd_ptr=wr_ptr=0, and out_valid=0 after the edge.
  - Flush has priority. A push or pop in the same cycle is discarded and has no effect.
  - in_ready stays combinationally (count<DEPTH) during the flush cycle, so IF is not frozen. Its fetch is dropped, but IF still advances to Branch_Address.
- Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH. count is a separate register and is never derived from pointer difference.
- Full (count=DEPTH):
  - in_ready=0, so IF must hold pc; in_valid is ignored.
  - A pop in a full cycle does not enable a same-cycle push. The push is accepted on the next cycle.
- Empty (count=0): out_ready is ignored and no pop occurs.
- Storage is a register array DEPTH x (2*DATA_W).

Test Plan:
- Async reset: after 3 pushes, drop rst to 0 between clock edges -> out_valid=0, count=0, pc_out=0, instr_out=0, in_ready=1 before the next edge. Release rst; the first push after release appears next cycle.
- Fill to full: out_ready=0; push (pc=1, 0xE3A00001) then (pc=2, 0xE3A01002).
  - After 2 edges: count=2, in_ready=0, pc_out=1, instr_out=0xE3A00001.
  - A third push (pc=3) is ignored; count stays 2.
- Drain order: from full, out_ready=1 for 3 cycles -> pc_out sequence 1, 2, then out_valid=0 with pc_out=0; count 2->1->0.
- Simultaneous push/pop at count=1 (head pc=5): push pc=6 with out_ready=1 -> after the edge count=1, pc_out=6.
- Flush priority: count=2, in_valid=1 (pc=7), out_ready=1, flush=1 -> after the edge count=0, out_valid=0, pc=7 not stored. Next cycle push pc=20 -> pc_out=20, count=1.
- Wrap-around: DEPTH=2, stream pcs 1..9 with out_ready toggling 1,0,1,0 -> outputs appear strictly in order 1..9, none lost or duplicated, count never exceeds 2.
